// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : Pipeline memory stage between the EX/MEM and MEM/WB registers.
//            Performs word/halfword/byte loads and stores against a data
//            memory using a req/ack handshake with a variable number of wait
//            states. It raises a combinational stall while an access is
//            outstanding, and flags misaligned accesses with a one-cycle
//            align_fault pulse.
// Optional : `define MEM_TIMEOUT_EN to abort an access when no ack arrives
//            within TIMEOUT ACCESS cycles. The abort reuses align_fault as
//            the error pulse.
// Ports    : clk, rst (async, active high)
//            EX/MEM in : in_valid, RegWrite, MemRead, MemWrite, MentoReg,
//                        Loadop[2:0], Saveop[1:0], ALUresult[31:0],
//                        dataB[31:0], Regadd[4:0]
//            memory    : mem_req, mem_we, mem_addr[ADDR_W-1:0], mem_be[3:0],
//                        mem_wdata[31:0] (all registered); mem_rdata,
//                        mem_ack (inputs)
//            control   : stall (combinational), align_fault (pulse)
//            MEM/WB out: wb_valid, wb_RegWrite, wb_MentoReg, wb_ALUdata,
//                        wb_MEMdata, wb_Regadd (all registered)
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              RegWrite,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MentoReg,
  input  logic [2:0]        Loadop,
  input  logic [1:0]        Saveop,
  input  logic [31:0]       ALUresult,
  input  logic [31:0]       dataB,
  input  logic [4:0]        Regadd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              wb_valid,
  output logic              wb_RegWrite,
  output logic              wb_MentoReg,
  output logic [31:0]       wb_ALUdata,
  output logic [31:0]       wb_MEMdata,
  output logic [4:0]        wb_Regadd,
  output logic              align_fault
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  localparam logic [1:0] c_SZ_BYTE = 2'd0;
  localparam logic [1:0] c_SZ_HALF = 2'd1;
  localparam logic [1:0] c_SZ_WORD = 2'd2;

  state_t      r_state;

  // Fields captured when an access is issued; used to build MEM/WB on ack.
  logic [2:0]  r_loadop;
  logic [1:0]  r_off;
  logic        r_is_read;
  logic        r_mentoreg;
  logic        r_regwrite;
  logic [4:0]  r_regadd;
  logic [31:0] r_aludata;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;
`endif

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic        w_memop;
  logic        w_is_read;
  logic [1:0]  w_size;
  logic        w_misaligned;
  logic        w_issue;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  always_comb begin
    w_memop   = MemRead | MemWrite;
    // Read wins when both MemRead and MemWrite are set.
    w_is_read = MemRead;
    w_size    = c_SZ_WORD;
    if (w_is_read) begin
      case (Loadop)
        3'b001, 3'b010: w_size = c_SZ_BYTE;
        3'b011, 3'b100: w_size = c_SZ_HALF;
        default:        w_size = c_SZ_WORD;
      endcase
    end else begin
      case (Saveop)
        2'b01:   w_size = c_SZ_BYTE;
        2'b10:   w_size = c_SZ_HALF;
        default: w_size = c_SZ_WORD;
      endcase
    end

    w_misaligned = ((w_size == c_SZ_HALF) && ALUresult[0]) ||
                   ((w_size == c_SZ_WORD) && (ALUresult[1:0] != 2'b00));

    w_issue = (r_state == S_IDLE) && in_valid && w_memop && !w_misaligned;

    // Store data is lane-replicated, so the byte enables alone pick the lane.
    w_be    = 4'b1111;
    w_wdata = 32'd0;
    if (!w_is_read) begin
      case (w_size)
        c_SZ_BYTE: begin
          w_be    = 4'b0001 << ALUresult[1:0];
          w_wdata = {4{dataB[7:0]}};
        end
        c_SZ_HALF: begin
          w_be    = ALUresult[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{dataB[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = dataB;
        end
      endcase
    end
  end

  // Upstream holds during the issue cycle and every ACCESS cycle without ack.
  assign stall = w_issue || ((r_state == S_ACCESS) && !mem_ack);

  // --------------------------------------------------------------------------
  // Load data alignment / extension
  // --------------------------------------------------------------------------
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  always_comb begin
    case (r_off)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_loadop)
      3'b001:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b010:  w_load = {24'd0, w_byte};
      3'b011:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {16'd0, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_loadop    <= 3'd0;
      r_off       <= 2'd0;
      r_is_read   <= 1'b0;
      r_mentoreg  <= 1'b0;
      r_regwrite  <= 1'b0;
      r_regadd    <= 5'd0;
      r_aludata   <= 32'd0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= 4'd0;
      mem_wdata   <= 32'd0;
      wb_valid    <= 1'b0;
      wb_RegWrite <= 1'b0;
      wb_MentoReg <= 1'b0;
      wb_ALUdata  <= 32'd0;
      wb_MEMdata  <= 32'd0;
      wb_Regadd   <= 5'd0;
      align_fault <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_cnt       <= '0;
`endif
    end else begin
      align_fault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!in_valid) begin
            wb_valid <= 1'b0;
          end else if (!w_memop) begin
            wb_valid    <= 1'b1;
            wb_RegWrite <= RegWrite;
            wb_MentoReg <= MentoReg;
            wb_ALUdata  <= ALUresult;
            wb_MEMdata  <= 32'd0;
            wb_Regadd   <= Regadd;
          end else if (w_misaligned) begin
            // Retire the instruction without a register write.
            wb_valid    <= 1'b1;
            wb_RegWrite <= 1'b0;
            wb_MentoReg <= MentoReg;
            wb_ALUdata  <= ALUresult;
            wb_MEMdata  <= 32'd0;
            wb_Regadd   <= Regadd;
            align_fault <= 1'b1;
          end else begin
            r_state    <= S_ACCESS;
            r_loadop   <= Loadop;
            r_off      <= ALUresult[1:0];
            r_is_read  <= w_is_read;
            r_mentoreg <= MentoReg;
            r_regwrite <= RegWrite;
            r_regadd   <= Regadd;
            r_aludata  <= ALUresult;
            mem_req    <= 1'b1;
            mem_we     <= !w_is_read;
            mem_addr   <= {ALUresult[ADDR_W-1:2], 2'b00};
            mem_be     <= w_be;
            mem_wdata  <= w_wdata;
            wb_valid   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_cnt      <= '0;
`endif
          end
        end

        S_ACCESS: begin
          wb_valid <= 1'b0;
          if (mem_ack) begin
            r_state     <= S_IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_be      <= 4'd0;
            wb_valid    <= 1'b1;
            wb_RegWrite <= r_regwrite;
            wb_MentoReg <= r_mentoreg;
            wb_ALUdata  <= r_aludata;
            wb_MEMdata  <= r_is_read ? w_load : 32'd0;
            wb_Regadd   <= r_regadd;
          end
`ifdef MEM_TIMEOUT_EN
          // This cycle is the TIMEOUT-th without an ack: abort.
          else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_state     <= S_IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_be      <= 4'd0;
            wb_valid    <= 1'b1;
            wb_RegWrite <= 1'b0;
            wb_MentoReg <= r_mentoreg;
            wb_ALUdata  <= r_aludata;
            wb_MEMdata  <= 32'd0;
            wb_Regadd   <= r_regadd;
            align_fault <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Purpose  : Directed self-checking bench for mem_access_stage. Expected
//            values are hand-computed constants. Build with
//            +define+MEM_TIMEOUT_EN to cover the timeout abort.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, RegWrite, MemRead, MemWrite, MentoReg;
  logic [2:0]  Loadop;
  logic [1:0]  Saveop;
  logic [31:0] ALUresult, dataB;
  logic [4:0]  Regadd;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack, stall;
  logic        wb_valid, wb_RegWrite, wb_MentoReg;
  logic [31:0] wb_ALUdata, wb_MEMdata;
  logic [4:0]  wb_Regadd;
  logic        align_fault;

  int total = 0;
  int bad   = 0;
  int cnt;

  mem_access_stage #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .MentoReg(MentoReg),
    .Loadop(Loadop), .Saveop(Saveop), .ALUresult(ALUresult), .dataB(dataB),
    .Regadd(Regadd), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .stall(stall), .wb_valid(wb_valid),
    .wb_RegWrite(wb_RegWrite), .wb_MentoReg(wb_MentoReg),
    .wb_ALUdata(wb_ALUdata), .wb_MEMdata(wb_MEMdata), .wb_Regadd(wb_Regadd),
    .align_fault(align_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; RegWrite = 0; MemRead = 0; MemWrite = 0; MentoReg = 0;
    Loadop = 3'b000; Saveop = 2'b00; ALUresult = 0; dataB = 0; Regadd = 0;
    mem_ack = 0; mem_rdata = 0;
  endtask

  // Issue a load; on return the stage is in its first ACCESS cycle.
  task automatic issue_load(input logic [2:0] op, input logic [31:0] addr, input logic [4:0] rd);
    in_valid = 1; MemRead = 1; MemWrite = 0; RegWrite = 1; MentoReg = 1;
    Loadop = op; ALUresult = addr; Regadd = rd;
    #1;
    chk("issue_stall", {31'd0, stall}, 32'd1);
    tick();
    in_valid = 0; MemRead = 0; RegWrite = 0; MentoReg = 0;
  endtask

  // Ack the outstanding load in the current cycle and check the result.
  task automatic ack_load(input string tag, input logic [31:0] rdata, input logic [31:0] exp);
    mem_rdata = rdata; mem_ack = 1;
    #1;
    chk({tag, "_ack_stall"}, {31'd0, stall}, 32'd0);
    tick();
    mem_ack = 0;
    chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd1);
    chk({tag, "_memdata"},  wb_MEMdata, exp);
    chk({tag, "_req_drop"}, {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    tick(); tick();
    // Reset state
    chk("rst_req",   {31'd0, mem_req}, 32'd0);
    chk("rst_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_fault", {31'd0, align_fault}, 32'd0);
    chk("rst_alu",   wb_ALUdata, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rst = 0;
    tick();

    // ALU op passes straight through with latency 1
    in_valid = 1; RegWrite = 1; ALUresult = 32'h1234; Regadd = 5;
    #1;
    chk("alu_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("alu_valid", {31'd0, wb_valid}, 32'd1);
    chk("alu_data",  wb_ALUdata, 32'h1234);
    chk("alu_rd",    {27'd0, wb_Regadd}, 32'd5);
    chk("alu_rw",    {31'd0, wb_RegWrite}, 32'd1);
    chk("alu_req",   {31'd0, mem_req}, 32'd0);
    idle_inputs();
    tick();
    chk("idle_valid", {31'd0, wb_valid}, 32'd0);

    // LB at 0x103 with 3 wait cycles: stall high for 4 cycles total
    issue_load(3'b001, 32'h103, 5'd7);
    chk("lb_req",  {31'd0, mem_req}, 32'd1);
    chk("lb_addr", mem_addr, 32'h100);
    chk("lb_we",   {31'd0, mem_we}, 32'd0);
    chk("lb_be",   {28'd0, mem_be}, 32'hF);
    cnt = 1;
    for (int i = 0; i < 3; i++) begin
      if (stall) cnt++;
      tick();
    end
    chk("lb_stall_cycles", cnt, 32'd4);
    chk("lb_req_hold", {31'd0, mem_req}, 32'd1);
    chk("lb_addr_hold", mem_addr, 32'h100);
    ack_load("lb", 32'h80FF_FF7F, 32'hFFFF_FF80);
    chk("lb_rd", {27'd0, wb_Regadd}, 32'd7);

    // LBU, ack in the first ACCESS cycle
    issue_load(3'b010, 32'h103, 5'd8);
    ack_load("lbu", 32'h80FF_FF7F, 32'h0000_0080);

    // LH upper half, sign-extended; LHU lower half, zero-extended
    issue_load(3'b011, 32'h102, 5'd9);
    ack_load("lh", 32'h8001_0000, 32'hFFFF_8001);
    issue_load(3'b100, 32'h100, 5'd9);
    ack_load("lhu", 32'h0000_9234, 32'h0000_9234);

    // SH at 0x202
    in_valid = 1; MemWrite = 1; Saveop = 2'b10; ALUresult = 32'h202;
    dataB = 32'hDEAD_BEEF; RegWrite = 0; Regadd = 3;
    tick();
    idle_inputs();
    chk("sh_we",    {31'd0, mem_we}, 32'd1);
    chk("sh_be",    {28'd0, mem_be}, 32'hC);
    chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    chk("sh_addr",  mem_addr, 32'h200);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("sh_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("sh_wb_rw",    {31'd0, wb_RegWrite}, 32'd0);
    chk("sh_memdata",  wb_MEMdata, 32'd0);

    // SB at odd address: no fault
    in_valid = 1; MemWrite = 1; Saveop = 2'b01; ALUresult = 32'h001;
    dataB = 32'h1234_5678;
    #1;
    chk("sb_stall", {31'd0, stall}, 32'd1);
    tick();
    idle_inputs();
    chk("sb_be",    {28'd0, mem_be}, 32'h2);
    chk("sb_wdata", mem_wdata, 32'h7878_7878);
    chk("sb_fault", {31'd0, align_fault}, 32'd0);
    mem_ack = 1;
    tick();
    mem_ack = 0;

    // Misaligned LW at 0x106
    in_valid = 1; MemRead = 1; Loadop = 3'b000; RegWrite = 1; ALUresult = 32'h106;
    #1;
    chk("mis_stall", {31'd0, stall}, 32'd0);
    tick();
    idle_inputs();
    chk("mis_req",   {31'd0, mem_req}, 32'd0);
    chk("mis_fault", {31'd0, align_fault}, 32'd1);
    chk("mis_valid", {31'd0, wb_valid}, 32'd1);
    chk("mis_rw",    {31'd0, wb_RegWrite}, 32'd0);
    tick();
    chk("mis_fault_pulse", {31'd0, align_fault}, 32'd0);

    // Stray ack while idle is ignored
    mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("idle_ack_req",   {31'd0, mem_req}, 32'd0);
    chk("idle_ack_valid", {31'd0, wb_valid}, 32'd0);

    // Reset mid-ACCESS, then a normal LW
    issue_load(3'b000, 32'h300, 5'd4);
    chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
    #2;
    rst = 1;
    #1;
    chk("async_rst_req",   {31'd0, mem_req}, 32'd0);
    chk("async_rst_valid", {31'd0, wb_valid}, 32'd0);
    #1;
    rst = 0;
    tick();
    chk("post_rst_stall", {31'd0, stall}, 32'd0);
    issue_load(3'b000, 32'h300, 5'd4);
    ack_load("lw", 32'hCAFE_F00D, 32'hCAFE_F00D);

    // No-ack access: timeout abort or indefinite wait
    issue_load(3'b000, 32'h40, 5'd2);
`ifdef MEM_TIMEOUT_EN
    cnt = 0;
    for (int i = 0; i < 10 && mem_req; i++) begin
      cnt++;
      tick();
    end
    chk("to_req_cycles", cnt, 32'd4);
    chk("to_req",   {31'd0, mem_req}, 32'd0);
    chk("to_fault", {31'd0, align_fault}, 32'd1);
    chk("to_rw",    {31'd0, wb_RegWrite}, 32'd0);
    chk("to_valid", {31'd0, wb_valid}, 32'd1);
`else
    for (int i = 0; i < 10; i++) tick();
    chk("wait_req",   {31'd0, mem_req}, 32'd1);
    chk("wait_stall", {31'd0, stall}, 32'd1);
    ack_load("late", 32'h0000_0055, 32'h0000_0055);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
